program_loader: RTL and testbench

//   Writer side of the instruction-memory interface: fills instruction RAM before fetch runs.

---
 rtl/loader_pkg.sv | 16 +
 rtl/word_assembler.sv | 45 ++++
 rtl/program_loader.sv | 142 ++++++++++++++
 tb/tb_program_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and framing constants for the program loader
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs bytes little-endian into a 32-bit word
// word_o already includes the byte being pushed, so the last byte is usable in its own cycle.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (push_i) begin
      word_d[8*idx_q +: 8] = byte_i;
      idx_d                = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_d;
  assign full_o = push_i && !clear_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - length-prefixed byte stream to instruction RAM writer
// Holds the CPU while an image is streamed in and written at consecutive word addresses.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam logic [32:0]       CAPACITY = 33'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  state_t            state_q, state_d;
  logic [31:0]       len_q, len_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       tcnt_q, tcnt_d;
  logic              done_q, done_d;
  logic              xfer, start_ok, timed_out, asm_full;
  logic [31:0]       asm_word;

  assign start_ok  = start_i && (state_q inside {IDLE, DONE, ERROR});
  assign xfer      = byte_valid_i && byte_ready_o;
  assign timed_out = (TIMEOUT != 0) && !xfer && (tcnt_q + 32'd1 >= TIMEOUT);

  word_assembler u_asm (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (start_ok),
    .push_i  (xfer),
    .byte_i  (byte_data_i),
    .word_o  (asm_word),
    .full_o  (asm_full)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERROR: if (start_i) state_d = HDR;
      HDR: begin
        if (asm_full) begin
          if (asm_word == 32'd0)                 state_d = DONE;
          else if ({1'b0, asm_word} > CAPACITY)  state_d = ERROR;
          else                                   state_d = DATA;
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      DATA: begin
        if (asm_full)       state_d = WRITE;
        else if (timed_out) state_d = ERROR;
      end
      WRITE:   state_d = (32'(wl_q) + 32'd1 == len_q) ? DONE : DATA;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    cpu_hold_o   = 1'b0;
    error_o      = 1'b0;
    unique case (state_q)
      HDR, DATA: begin
        byte_ready_o = 1'b1;
        cpu_hold_o   = 1'b1;
      end
      WRITE: begin
        mem_we_o   = 1'b1;
        cpu_hold_o = 1'b1;
      end
      ERROR: begin
        error_o    = 1'b1;
        cpu_hold_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Address and data are captured with the last byte so the WRITE cycle drives them directly.
  always_comb begin
    len_d   = len_q;
    wl_d    = wl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tcnt_d  = '0;
    done_d  = (state_d == DONE) && (state_q != DONE);
    if (start_ok) wl_d = '0;
    if (state_q == HDR && asm_full) len_d = asm_word;
    if (state_q == DATA && asm_full) begin
      addr_d  = BASE + wl_q[ADDR_W-1:0];
      wdata_d = asm_word;
    end
    if (state_q == WRITE) wl_d = wl_q + (ADDR_W+1)'(1);
    if ((state_q == HDR || state_q == DATA) && !xfer) tcnt_d = tcnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      len_q   <= '0;
      wl_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      len_q   <= len_d;
      wl_q    <= wl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign done_o         = done_q;
  assign words_loaded_o = wl_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

  localparam int AW = 8;

  typedef struct {
    int            d;
    logic [AW-1:0] a;
    logic [31:0]   w;
    int            c;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start [2];
  logic          bv    [2];
  logic [7:0]    bd    [2];
  logic          br    [2];
  logic          we    [2];
  logic [AW-1:0] ma    [2];
  logic [31:0]   wd    [2];
  logic          hold  [2];
  logic          dn    [2];
  logic          er    [2];
  logic [AW:0]   wl    [2];

  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;
  int  done_cnt [2];
  int  done_cyc [2];
  wr_t got_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  program_loader #(.ADDR_W(AW), .BASE_ADDR(0), .TIMEOUT(16)) u_dut_a (
    .clk_i(clk), .reset_i(rst), .start_i(start[0]), .byte_valid_i(bv[0]),
    .byte_data_i(bd[0]), .byte_ready_o(br[0]), .mem_we_o(we[0]), .mem_addr_o(ma[0]),
    .mem_wdata_o(wd[0]), .cpu_hold_o(hold[0]), .done_o(dn[0]), .error_o(er[0]),
    .words_loaded_o(wl[0])
  );

  program_loader #(.ADDR_W(AW), .BASE_ADDR(254), .TIMEOUT(0)) u_dut_b (
    .clk_i(clk), .reset_i(rst), .start_i(start[1]), .byte_valid_i(bv[1]),
    .byte_data_i(bd[1]), .byte_ready_o(br[1]), .mem_we_o(we[1]), .mem_addr_o(ma[1]),
    .mem_wdata_o(wd[1]), .cpu_hold_o(hold[1]), .done_o(dn[1]), .error_o(er[1]),
    .words_loaded_o(wl[1])
  );

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (we[d]) got_q.push_back('{d, ma[d], wd[d], cyc});
      if (dn[d]) begin
        done_cnt[d] = done_cnt[d] + 1;
        done_cyc[d] = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input int d, input string tag);
    check({tag, ".ready"}, 64'(br[d]), 64'd0);
    check({tag, ".we"},    64'(we[d]), 64'd0);
    check({tag, ".addr"},  64'(ma[d]), 64'd0);
    check({tag, ".wdata"}, 64'(wd[d]), 64'd0);
    check({tag, ".hold"},  64'(hold[d]), 64'd0);
    check({tag, ".done"},  64'(dn[d]), 64'd0);
    check({tag, ".error"}, 64'(er[d]), 64'd0);
    check({tag, ".wl"},    64'(wl[d]), 64'd0);
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  // Present one byte and hold it until accepted; xc is the cycle stamp just before the transfer edge.
  task automatic send_byte(input int d, input logic [7:0] b, output int xc);
    int guard;
    bv[d] = 1'b1;
    bd[d] = b;
    guard = 0;
    @(negedge clk);
    while (!br[d] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("ready_wait", 64'd0, 64'd1);
    xc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic gen_load(input int n, output logic [7:0] q[$]);
    q.delete();
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    q.push_back(8'h00);
    q.push_back(8'h00);
    for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
  endtask

  // Reference model: length from the 4 header bytes, then N little-endian words at base+k mod 2**AW.
  task automatic run_load(input int d, input logic [7:0] bytes[$], input int maxgap, input string tag);
    longint n;
    int     base, nsend, xc, g, nw;
    bit     bad;
    int     exp_c [$];
    logic [31:0] exp_w;
    base = (d == 0) ? 0 : 254;
    n = longint'(bytes[0]) + longint'(bytes[1]) * 256 + longint'(bytes[2]) * 65536
        + longint'(bytes[3]) * 16777216;
    bad   = (n > (64'd1 << AW));
    nw    = bad ? 0 : int'(n);
    nsend = 4 + 4 * nw;
    got_q.delete();
    done_cnt[d] = 0;
    pulse_start(d);
    check({tag, ".hold_on"},   64'(hold[d]), 64'd1);
    check({tag, ".err_clear"}, 64'(er[d]), 64'd0);
    check({tag, ".wl_clear"},  64'(wl[d]), 64'd0);
    for (int i = 0; i < nsend; i++) begin
      send_byte(d, bytes[i], xc);
      if (i % 4 == 3) exp_c.push_back(xc + 1);
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      if (g > 0) begin
        bv[d] = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
    end
    bv[d] = 1'b0;
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    check({tag, ".nwrites"}, 64'(got_q.size()), 64'(nw));
    for (int k = 0; k < nw && k < got_q.size(); k++) begin
      exp_w = {bytes[4+4*k+3], bytes[4+4*k+2], bytes[4+4*k+1], bytes[4+4*k]};
      check({tag, ".addr"},  64'(got_q[k].a), 64'((base + k) % (1 << AW)));
      check({tag, ".wdata"}, 64'(got_q[k].w), 64'(exp_w));
      check({tag, ".wcyc"},  64'(got_q[k].c), 64'(exp_c[k+1]));
    end
    check({tag, ".ndone"}, 64'(done_cnt[d]), bad ? 64'd0 : 64'd1);
    if (!bad && done_cnt[d] > 0)
      check({tag, ".done_cyc"}, 64'(done_cyc[d]), 64'(nw == 0 ? exp_c[0] : exp_c[nw] + 1));
    check({tag, ".hold_end"}, 64'(hold[d]), 64'(bad));
    check({tag, ".error"},    64'(er[d]), 64'(bad));
    check({tag, ".wl"},       64'(wl[d]), 64'(nw));
    check({tag, ".ready_end"}, 64'(br[d]), 64'd0);
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] t1 [$];
    int xc;
    start = '{1'b0, 1'b0};
    bv    = '{1'b0, 1'b0};
    bd    = '{8'h00, 8'h00};
    done_cnt = '{0, 0};
    done_cyc = '{0, 0};
    #1 rst = 1'b1;
    #2;
    check_reset(0, "rst_a");
    check_reset(1, "rst_b");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    t1 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(0, t1, 0, "t1");

    q = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_load(0, q, 0, "t2_empty");

    gen_load(257, q);
    run_load(0, q, 0, "t3_257");
    q = '{8'h01, 8'h00, 8'h00, 8'h01};
    run_load(0, q, 0, "t3_big");
    gen_load(1, q);
    run_load(0, q, 0, "t3_after");

    got_q.delete();
    done_cnt[0] = 0;
    pulse_start(0);
    q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    for (int i = 0; i < 6; i++) send_byte(0, q[i], xc);
    bv[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("t4.err_early", 64'(er[0]), 64'd0);
    @(posedge clk); #1;
    check("t4.err",     64'(er[0]), 64'd1);
    check("t4.hold",    64'(hold[0]), 64'd1);
    check("t4.ready",   64'(br[0]), 64'd0);
    check("t4.nwrites", 64'(got_q.size()), 64'd0);
    check("t4.ndone",   64'(done_cnt[0]), 64'd0);

    gen_load(3, q);
    run_load(1, q, 0, "t5_wrap");

    pulse_start(0);
    gen_load(3, q);
    for (int i = 0; i < 10; i++) send_byte(0, q[i], xc);
    #2 rst = 1'b1;
    #1;
    check_reset(0, "t6_rst");
    bv[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    run_load(0, t1, 0, "t6_rerun");

    for (int r = 0; r < 5; r++) begin
      gen_load(int'($urandom_range(1, 5)), q);
      run_load(0, q, 3, "rand_a");
    end
    for (int r = 0; r < 3; r++) begin
      gen_load(int'($urandom_range(1, 4)), q);
      run_load(1, q, 0, "rand_b");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
